fractal_sync_port_arb: RTL and testbench

FRACTAL_SYNC_PORT_ARB -- requirements
Module: fractal_sync_port_arb

---
 rtl/fractal_sync_pkg.sv | 27 ++
 rtl/fractal_sync_rr_arb.sv | 25 ++
 rtl/fractal_sync_port_arb.sv | 137 +++++++++++++
 tb/tb_fractal_sync_port_arb.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal sync port arbiter: FSM state encoding and
// the default request/response structs used when no custom types are supplied.
package fractal_sync_pkg;

  // Arbiter FSM states; exported on the arbiter's debug port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fsync_arb_state_e;

  localparam int unsigned FSYNC_DST_W = 8;

  // Default request: a single sync pulse.
  typedef struct packed {
    logic sync;
  } fsync_req_s;

  // Default response: wake/error flags plus a destination tag.
  typedef struct packed {
    logic                   wake;
    logic [FSYNC_DST_W-1:0] dst;
    logic                   error;
  } fsync_rsp_s;

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// Combinational round-robin picker: returns the first set bit of req at or
// after ptr, wrapping around N_REQ.
module fractal_sync_rr_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[IDX_W'((int'(ptr) + k) % N_REQ)]) begin
        idx   = IDX_W'((int'(ptr) + k) % N_REQ);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fractal_sync_port_arb.sv
// Shares one sync port into the neighbor/tree node among N_REQ local
// requesters. Requests are latched as pending bits, served one at a time in
// round-robin order, and each served requester receives exactly one
// wake or error response. Optional timeout turns a missing wake into an error.
module fractal_sync_port_arb
  import fractal_sync_pkg::*;
#(
  parameter type         fsync_req_t = fsync_req_s,
  parameter type         fsync_rsp_t = fsync_rsp_s,
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT     = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  fsync_req_t       req_i [N_REQ],
  output fsync_rsp_t       rsp_o [N_REQ],
  output fsync_req_t       node_req_o,
  input  fsync_rsp_t       node_rsp_i,
  output fsync_arb_state_e state_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TMR_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  // Timer value of the last WAIT cycle before the timeout fires.
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);

  fsync_arb_state_e state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  // Only wake/error of the node response matter; the rest is deliberately dropped.
  logic unused_node_rsp;
  assign unused_node_rsp = ^node_rsp_i;

  fractal_sync_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req   (pending_q),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // State and datapath registers; reset drops any in-flight request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: pending capture, FSM transitions, timer and outputs.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    err_d      = err_q;
    node_req_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_o[i] = '0;
    end

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        node_req_o.sync     = 1'b1;
        pending_d[grant_q]  = 1'b0;
        timer_d             = '0;
        state_d             = WAIT;
      end
      WAIT: begin
        // Priority: error, then wake, then timeout.
        if (node_rsp_i.error) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (node_rsp_i.wake) begin
          err_d   = 1'b0;
          state_d = RESP;
        end else if (TIMEOUT != 0) begin
          if (timer_q == TMR_LAST) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      RESP: begin
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_q == IDX_W'(i)) begin
            rsp_o[i].wake  = !err_q;
            rsp_o[i].error = err_q;
          end
        end
        ptr_d   = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new pulse always lands, even for the requester just issued, so a
    // re-request is never lost.
    for (int i = 0; i < N_REQ; i++) begin
      if (req_i[i].sync) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_fractal_sync_port_arb.sv
// Directed bench for fractal_sync_port_arb with N_REQ=4, TIMEOUT=16.
module tb_fractal_sync_port_arb;
  import fractal_sync_pkg::*;

  localparam int K_WAKE = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic             clk_i;
  logic             rst_ni;
  fsync_req_s       req_i [4];
  fsync_rsp_s       rsp_o [4];
  fsync_req_s       node_req_o;
  fsync_rsp_s       node_rsp_i;
  fsync_arb_state_e state_o;

  int n_checks = 0;
  int n_err    = 0;

  fractal_sync_port_arb #(
    .fsync_req_t (fsync_req_s),
    .fsync_rsp_t (fsync_rsp_s),
    .N_REQ       (4),
    .TIMEOUT     (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .rsp_o      (rsp_o),
    .node_req_o (node_req_o),
    .node_rsp_i (node_rsp_i),
    .state_o    (state_o)
  );

  // Clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Observed output bundle: {sync, wake[3:0], error[3:0], any dst bit set}.
  function automatic logic [9:0] observe();
    logic [3:0] wv, ev;
    logic       dnz;
    wv  = '0;
    ev  = '0;
    dnz = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wv[i] = rsp_o[i].wake;
      ev[i] = rsp_o[i].error;
      dnz   = dnz | (|rsp_o[i].dst);
    end
    return {node_req_o.sync, wv, ev, dnz};
  endfunction

  task automatic check(input logic [9:0] exp, input string tag);
    logic [9:0] obs;
    obs = observe();
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_state(input fsync_arb_state_e exp, input string tag);
    n_checks++;
    assert (state_o === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, state_o, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check at mid-cycle.
  task automatic cyc(input logic [3:0] req, input logic wake, input logic err,
                     input logic exp_sync, input logic [3:0] exp_wake,
                     input logic [3:0] exp_err, input string tag);
    for (int i = 0; i < 4; i++) req_i[i].sync = req[i];
    node_rsp_i       = '0;
    node_rsp_i.wake  = wake;
    node_rsp_i.error = err;
    node_rsp_i.dst   = 8'hA5;
    @(negedge clk_i);
    check({exp_sync, exp_wake, exp_err, 1'b0}, tag);
    @(posedge clk_i);
    #1;
  endtask

  // One arbitration round starting at the IDLE cycle that picks requester g.
  // d = WAIT cycles including the one carrying the node response.
  task automatic round(input int g, input int d, input int kind,
                       input logic [3:0] req_idle, input logic [3:0] req_wait,
                       input string tag);
    logic [3:0] oh;
    logic       w, e;
    oh = 4'b0001 << g;
    cyc(req_idle, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, {tag, "/idle"});
    cyc(4'b0, 1'b1, 1'b0, 1'b1, 4'b0, 4'b0, {tag, "/issue"});
    for (int k = 1; k <= d; k++) begin
      w = (k == d) && (kind == K_WAKE || kind == K_BOTH);
      e = (k == d) && (kind == K_ERR || kind == K_BOTH);
      cyc(req_wait, w, e, 1'b0, 4'b0, 4'b0, {tag, "/wait"});
    end
    cyc(4'b0, 1'b1, 1'b1, 1'b0, (kind == K_WAKE) ? oh : 4'b0,
        (kind == K_WAKE) ? 4'b0 : oh, {tag, "/resp"});
  endtask

  // Idle cycles with stray node responses that must be ignored.
  task automatic quiet(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      cyc(4'b0, 1'b1, 1'b1, 1'b0, 4'b0, 4'b0, tag);
    end
  endtask

  // Directed sequence
  initial begin
    rst_ni     = 1'b0;
    node_rsp_i = '0;
    for (int i = 0; i < 4; i++) req_i[i] = '0;

    // Reset state
    repeat (3) begin
      @(negedge clk_i);
      check(10'b0, "reset/outputs");
    end
    check_state(IDLE, "reset/state");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Fairness: all four pulse together, served 0,1,2,3, nothing extra
    cyc(4'b1111, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, "fair/pulse");
    round(0, 2, K_WAKE, 4'b0, 4'b0, "fair0");
    round(1, 2, K_WAKE, 4'b0, 4'b0, "fair1");
    round(2, 2, K_WAKE, 4'b0, 4'b0, "fair2");
    round(3, 2, K_WAKE, 4'b0, 4'b0, "fair3");
    quiet(3, "fair/after");

    // Single request on 2: sync in cycle 2, wake in 5, response in 6
    cyc(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, "single/pulse");
    round(2, 3, K_WAKE, 4'b0, 4'b0, "single");
    quiet(2, "single/after");

    // Pointer now 3: requesters 0 and 3 together -> 3 first, then 0
    cyc(4'b1001, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, "ptr/pulse");
    round(3, 2, K_WAKE, 4'b0, 4'b0, "ptr3");
    round(0, 2, K_WAKE, 4'b0, 4'b0, "ptr0");
    quiet(2, "ptr/after");

    // Timeout on requester 1: error 16 cycles after entering WAIT
    cyc(4'b0010, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, "tmo/pulse");
    round(1, 16, K_NONE, 4'b0, 4'b0, "tmo");
    quiet(2, "tmo/after");

    // Wake and error together: error wins
    cyc(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, "both/pulse");
    round(2, 2, K_BOTH, 4'b0, 4'b0, "both");

    // Wake in the timeout cycle: wake wins
    cyc(4'b1000, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, "tmowake/pulse");
    round(3, 16, K_WAKE, 4'b0, 4'b0, "tmowake");
    quiet(2, "tmowake/after");

    // Re-request from 0 during WAIT -> second issue for 0
    cyc(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, "rereq/pulse");
    round(0, 2, K_WAKE, 4'b0001, 4'b0001, "rereq1");
    round(0, 2, K_WAKE, 4'b0, 4'b0, "rereq2");
    quiet(3, "rereq/after");

    // Three pulses from 3 while busy with 1 -> one issue for 3 only
    cyc(4'b0010, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, "absorb/pulse");
    round(1, 3, K_WAKE, 4'b0, 4'b1000, "absorb1");
    round(3, 2, K_ERR, 4'b0, 4'b0, "absorb3");
    quiet(3, "absorb/after");

    // Reset during WAIT: outputs drop at once, no late response
    cyc(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, "rst/pulse");
    cyc(4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, "rst/idle");
    cyc(4'b0, 1'b0, 1'b0, 1'b1, 4'b0, 4'b0, "rst/issue");
    check_state(WAIT, "rst/inwait");
    rst_ni = 1'b0;
    #1;
    check(10'b0, "rst/async_outputs");
    check_state(IDLE, "rst/async_state");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    quiet(4, "rst/no_late");
    check_state(IDLE, "rst/after_state");

    // Pointer cleared by reset: 1 and 3 pending -> 1 first
    cyc(4'b1010, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, "rstptr/pulse");
    round(1, 2, K_WAKE, 4'b0, 4'b0, "rstptr1");
    round(3, 2, K_WAKE, 4'b0, 4'b0, "rstptr3");
    quiet(2, "rstptr/after");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
